// File: rtl/icache_refill_pkg.sv
// Shared definitions for the I-cache miss-refill engine: FSM encoding,
// AXI burst constants and default cache geometry (64 B lines, 128 sets).
package icache_refill_pkg;

  localparam int DEF_IDX_LEN = 7;
  localparam int DEF_BLK_LEN = 6;
  localparam int DEF_TAG_LEN = 32 - DEF_IDX_LEN - DEF_BLK_LEN;

  localparam int         LINE_BEATS = 16;
  localparam logic [7:0] AR_LEN     = 8'(LINE_BEATS - 1);
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_RDATA,
    S_DONE
  } state_t;

endpackage

// File: rtl/icache_refill_lane.sv
// Maps the beat counter onto the data array: 16-byte bank address, 32-bit
// lane mask and the beat replicated across all four lanes. Pure combinational.
module icache_refill_lane (
  input  logic         en,
  input  logic [3:0]   burst_count,
  input  logic [31:0]  beat,
  output logic [5:0]   blk_addr,
  output logic [127:0] wmask,
  output logic [127:0] wdata
);

  localparam logic [127:0] LANE_ONES = {96'd0, 32'hFFFF_FFFF};

  assign blk_addr = {burst_count[3:2], 4'b0000};
  assign wmask    = en ? (LANE_ONES << {burst_count[1:0], 5'b00000}) : '0;
  assign wdata    = en ? {4{beat}} : '0;

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill: one 16-beat AXI4 INCR burst per line, beats steered into
// the data array, tag/valid written on clean completion. ICACHE_CRIT_FWD_EN adds critical-word forwarding.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int IDX_LEN = DEF_IDX_LEN,
  parameter int BLK_LEN = DEF_BLK_LEN,
  parameter int BEAT_W  = 32,
  parameter int TAG_LEN = ADDR_W - IDX_LEN - BLK_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req_i,
  input  logic [ADDR_W-1:0]  miss_addr_i,
  output logic               refill_busy_o,
  output logic               refill_done_o,
  output logic               refill_err_o,
  output logic               axi_ar_valid_o,
  input  logic               axi_ar_ready_i,
  output logic [ADDR_W-1:0]  axi_ar_addr_o,
  output logic [7:0]         axi_ar_len_o,
  output logic [2:0]         axi_ar_size_o,
  output logic [1:0]         axi_ar_burst_o,
  input  logic               axi_r_valid_i,
  output logic               axi_r_ready_o,
  input  logic [BEAT_W-1:0]  axi_r_data_i,
  input  logic [1:0]         axi_r_resp_i,
  input  logic               axi_r_last_i,
  output logic [IDX_LEN-1:0] icache_index_o,
  output logic [BLK_LEN-1:0] icache_blk_addr_o,
  output logic [127:0]       icache_line_wdata_o,
  output logic [127:0]       icache_wmask_o,
  output logic [3:0]         burst_count_o,
  output logic               icache_wen_o,
  output logic               tag_wen_o,
  output logic [IDX_LEN-1:0] tag_index_o,
  output logic [TAG_LEN-1:0] tag_o
`ifdef ICACHE_CRIT_FWD_EN
  ,
  output logic               fwd_valid_o,
  output logic [BEAT_W-1:0]  fwd_data_o
`endif
);

  state_t state, state_nxt;
  logic [ADDR_W-BLK_LEN-1:0] line_q;
  logic [3:0]                cnt_q;
  logic                      err_q;
  logic                      beat_hs;
  logic                      final_beat;

  assign beat_hs    = (state == S_RDATA) && axi_r_valid_i;
  assign final_beat = (cnt_q == 4'(LINE_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // The beat count decides completion; r_last only cross-checks it, so any
  // disagreement (early or missing last) marks the line bad.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (miss_req_i) begin
        line_q <= miss_addr_i[ADDR_W-1:BLK_LEN];
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
    end else if (beat_hs) begin
      cnt_q <= axi_r_last_i ? 4'd0 : cnt_q + 4'd1;
      if ((axi_r_resp_i != RESP_OKAY) || (axi_r_last_i != final_beat))
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    icache_wen_o   = 1'b0;
    refill_done_o  = 1'b0;
    refill_err_o   = 1'b0;
    tag_wen_o      = 1'b0;
    case (state)
      S_IDLE:  if (miss_req_i) state_nxt = S_AR;
      S_AR: begin
        axi_ar_valid_o = 1'b1;
        if (axi_ar_ready_i) state_nxt = S_RDATA;
      end
      S_RDATA: begin
        axi_r_ready_o = 1'b1;
        icache_wen_o  = axi_r_valid_i;
        if (beat_hs && (final_beat || axi_r_last_i)) state_nxt = S_DONE;
      end
      S_DONE: begin
        refill_done_o = 1'b1;
        refill_err_o  = err_q;
        tag_wen_o     = !err_q;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign refill_busy_o  = (state != S_IDLE);
  assign axi_ar_addr_o  = {line_q, {BLK_LEN{1'b0}}};
  assign axi_ar_len_o   = AR_LEN;
  assign axi_ar_size_o  = SIZE_4B;
  assign axi_ar_burst_o = BURST_INCR;
  assign burst_count_o  = cnt_q;
  assign icache_index_o = line_q[IDX_LEN-1:0];
  assign tag_index_o    = line_q[IDX_LEN-1:0];
  assign tag_o          = line_q[ADDR_W-BLK_LEN-1 -: TAG_LEN];

  icache_refill_lane u_lane (
    .en          (beat_hs),
    .burst_count (cnt_q),
    .beat        (axi_r_data_i),
    .blk_addr    (icache_blk_addr_o),
    .wmask       (icache_wmask_o),
    .wdata       (icache_line_wdata_o)
  );

`ifdef ICACHE_CRIT_FWD_EN
  logic [3:0] crit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             crit_q <= '0;
    else if (state == S_IDLE && miss_req_i) crit_q <= miss_addr_i[5:2];
  end

  assign fwd_valid_o = beat_hs && (cnt_q == crit_q) && (axi_r_resp_i == RESP_OKAY);
  assign fwd_data_o  = fwd_valid_o ? axi_r_data_i : '0;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: AXI slave driven cycle by cycle from
// per-test parameters, outputs sampled at the falling edge.
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         refill_busy_o, refill_done_o, refill_err_o;
  logic         axi_ar_valid_o;
  logic         axi_ar_ready = 1'b0;
  logic [31:0]  axi_ar_addr_o;
  logic [7:0]   axi_ar_len_o;
  logic [2:0]   axi_ar_size_o;
  logic [1:0]   axi_ar_burst_o;
  logic         axi_r_valid = 1'b0;
  logic         axi_r_ready_o;
  logic [31:0]  axi_r_data = '0;
  logic [1:0]   axi_r_resp = '0;
  logic         axi_r_last = 1'b0;
  logic [6:0]   icache_index_o;
  logic [5:0]   icache_blk_addr_o;
  logic [127:0] icache_line_wdata_o, icache_wmask_o;
  logic [3:0]   burst_count_o;
  logic         icache_wen_o, tag_wen_o;
  logic [6:0]   tag_index_o;
  logic [18:0]  tag_o;
`ifdef ICACHE_CRIT_FWD_EN
  logic         fwd_valid_o;
  logic [31:0]  fwd_data_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [6:0]  last_tag_index;
  logic [18:0] last_tag;

  always #5 clk = ~clk;

  icache_refill dut (
    .clk                 (clk),
    .rst                 (rst),
    .miss_req_i          (miss_req),
    .miss_addr_i         (miss_addr),
    .refill_busy_o       (refill_busy_o),
    .refill_done_o       (refill_done_o),
    .refill_err_o        (refill_err_o),
    .axi_ar_valid_o      (axi_ar_valid_o),
    .axi_ar_ready_i      (axi_ar_ready),
    .axi_ar_addr_o       (axi_ar_addr_o),
    .axi_ar_len_o        (axi_ar_len_o),
    .axi_ar_size_o       (axi_ar_size_o),
    .axi_ar_burst_o      (axi_ar_burst_o),
    .axi_r_valid_i       (axi_r_valid),
    .axi_r_ready_o       (axi_r_ready_o),
    .axi_r_data_i        (axi_r_data),
    .axi_r_resp_i        (axi_r_resp),
    .axi_r_last_i        (axi_r_last),
    .icache_index_o      (icache_index_o),
    .icache_blk_addr_o   (icache_blk_addr_o),
    .icache_line_wdata_o (icache_line_wdata_o),
    .icache_wmask_o      (icache_wmask_o),
    .burst_count_o       (burst_count_o),
    .icache_wen_o        (icache_wen_o),
    .tag_wen_o           (tag_wen_o),
    .tag_index_o         (tag_index_o),
    .tag_o               (tag_o)
`ifdef ICACHE_CRIT_FWD_EN
    ,
    .fwd_valid_o         (fwd_valid_o),
    .fwd_data_o          (fwd_data_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    miss_req     = 1'b0;
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b0;
    axi_r_last   = 1'b0;
    axi_r_resp   = 2'b00;
    axi_r_data   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  refill_busy_o, 0);
    check_eq({tag, "_arv"},   axi_ar_valid_o, 0);
    check_eq({tag, "_rrdy"},  axi_r_ready_o, 0);
    check_eq({tag, "_wen"},   icache_wen_o, 0);
    check_eq({tag, "_done"},  refill_done_o, 0);
    check_eq({tag, "_twen"},  tag_wen_o, 0);
    check_eq({tag, "_cnt"},   burst_count_o, 0);
    check_eq({tag, "_idx"},   icache_index_o, 0);
    check_eq({tag, "_wmask"}, icache_wmask_o, 0);
    check_eq({tag, "_wdata"}, icache_line_wdata_o, 0);
    check_eq({tag, "_araddr"}, axi_ar_addr_o, 0);
  endtask

  // One refill: slave behaviour set by ar_delay, gaps, bad_beat (SLVERR),
  // last_beat (where r_last is raised) and rst_beat (async reset after that beat).
  task automatic run_refill(input logic [31:0] addr, input int ar_delay, input bit gaps,
                            input int bad_beat, input int last_beat, input int rst_beat,
                            input bit hold, input bit exp_err, input int exp_beats,
                            input int exp_done_cyc);
    int cyc = 0, beat = 0, ar_wait = 0, ar_hs = 0, done_cnt = 0, done_cyc = -1;
    int fwd_cnt = 0;
    bit done_seen = 0, aborted = 0, hs;
    logic [31:0]  data;
    logic [127:0] mask;
    @(negedge clk);
    miss_req  = 1'b1;
    miss_addr = addr;
    #1;
    check_eq("busy_pre", refill_busy_o, 0);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      if (done_seen) begin
        miss_req = 1'b0;
        #1;
        check_eq("busy_after_done", refill_busy_o, 0);
        check_eq("arv_after_done", axi_ar_valid_o, 0);
        break;
      end
      miss_req     = hold;
      axi_ar_ready = 1'b0;
      if (axi_ar_valid_o) begin
        check_eq("ar_addr", axi_ar_addr_o, {addr[31:6], 6'b0});
        check_eq("ar_len", axi_ar_len_o, 15);
        check_eq("ar_single", ar_hs, 0);
        if (ar_wait >= ar_delay) begin
          axi_ar_ready = 1'b1;
          ar_hs++;
        end
        ar_wait++;
      end else if (ar_wait > 0 && ar_hs == 0) begin
        check_eq("ar_valid_held", axi_ar_valid_o, 1);
      end
      axi_r_valid = 1'b0;
      axi_r_last  = 1'b0;
      axi_r_resp  = 2'b00;
      axi_r_data  = '0;
      data        = {16'hC0DE, 8'(beat), 8'(255 - beat)};
      if (axi_r_ready_o) begin
        axi_r_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        axi_r_data  = data;
        axi_r_resp  = (beat == bad_beat) ? 2'b10 : 2'b00;
        axi_r_last  = (beat == last_beat);
      end
      #1;
      hs = axi_r_valid && axi_r_ready_o;
      check_eq("wen_vs_hs", icache_wen_o, hs);
`ifdef ICACHE_CRIT_FWD_EN
      check_eq("fwd_valid", fwd_valid_o, hs && (beat == int'(addr[5:2])) && (beat != bad_beat));
      if (fwd_valid_o) begin
        check_eq("fwd_data", fwd_data_o, data);
        fwd_cnt++;
      end
`endif
      if (hs) begin
        mask = 128'hFFFF_FFFF;
        mask = mask << ((beat % 4) * 32);
        check_eq("burst_count", burst_count_o, beat);
        check_eq("blk_addr", icache_blk_addr_o, (beat / 4) * 16);
        check_eq("wmask", icache_wmask_o, mask);
        check_eq("wdata", icache_line_wdata_o, {data, data, data, data});
        check_eq("data_index", icache_index_o, addr[12:6]);
        if (beat == rst_beat) begin
          rst = 1'b0;
          #1;
          check_all_zero("midrst");
          aborted = 1;
          idle_inputs();
          @(negedge clk);
          rst = 1'b1;
          break;
        end
        beat++;
      end
      if (refill_done_o) begin
        done_cnt++;
        done_seen = 1;
        done_cyc  = cyc;
        check_eq("done_err", refill_err_o, exp_err);
        check_eq("tag_wen", tag_wen_o, !exp_err);
        check_eq("tag_index", tag_index_o, addr[12:6]);
        check_eq("tag", tag_o, addr[31:13]);
        last_tag_index = tag_index_o;
        last_tag       = tag_o;
      end else begin
        check_eq("tag_wen_idle", tag_wen_o, 0);
      end
    end
    idle_inputs();
    if (!aborted) begin
      check_eq("beats", beat, exp_beats);
      check_eq("done_once", done_cnt, 1);
      check_eq("ar_hs_once", ar_hs, 1);
      if (exp_done_cyc >= 0) check_eq("miss_to_done", done_cyc, exp_done_cyc);
`ifdef ICACHE_CRIT_FWD_EN
      check_eq("fwd_count", fwd_cnt,
               (int'(addr[5:2]) < exp_beats && int'(addr[5:2]) != bad_beat) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    // Inputs active during reset must not leak to any output.
    miss_req    = 1'b1;
    miss_addr   = 32'hFFFF_FFFF;
    axi_r_valid = 1'b1;
    axi_r_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    check_eq("rst_len", axi_ar_len_o, 15);
    check_eq("rst_size", axi_ar_size_o, 3'b010);
    check_eq("rst_burst", axi_ar_burst_o, 2'b01);
    idle_inputs();
    rst = 1'b1;

    // Zero-wait refill: request cycle through done cycle spans 19 cycles.
    run_refill(32'h8000_1234, 0, 0, -1, 15, -1, 0, 0, 16, 18);
    check_eq("hand_index", last_tag_index, 7'h48);
    check_eq("hand_tag", last_tag, 19'h40000);

    // Slow AR and random R gaps.
    run_refill(32'h1234_5678, 5, 1, -1, 15, -1, 0, 0, 16, -1);

    // SLVERR on beat 7: whole line written, no tag write.
    run_refill(32'h0000_0A80, 0, 0, 7, 15, -1, 0, 1, 16, 18);

    // Early r_last on beat 9.
    run_refill(32'h4000_2040, 0, 0, -1, 9, -1, 0, 1, 10, -1);

    // No r_last at all on beat 15.
    run_refill(32'h7FFF_FFC0, 2, 0, -1, 99, -1, 0, 1, 16, -1);

    // Async reset at beat 5, then a clean burst from beat 0.
    run_refill(32'h9000_0100, 0, 0, -1, 15, 5, 0, 0, 16, -1);
    run_refill(32'h0000_0FC4, 0, 0, -1, 15, -1, 0, 0, 16, 18);

    // Critical word in the last beat; miss held high for the whole refill.
    run_refill(32'h8000_003C, 1, 1, -1, 15, -1, 1, 0, 16, -1);

    repeat (2) @(negedge clk);
    check_eq("final_idle", refill_busy_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss-refill engine for the I-cache, directly upstream of the I-cache data array.
- On a miss request it issues one AXI4 INCR read burst for the whole 64-byte line.
- Each 32-bit beat is steered into the correct 128-bit SRAM bank and word lane via burst count, write mask and write enable.
- On completion it writes the tag/valid entry and signals done to the fetch stage.

Parameters:
ADDR_W, 32, physical address width
IDX_LEN, 7, set index width (128 sets)
BLK_LEN, 6, line offset width (64-byte line)
BEAT_W, 32, AXI R data width; beats per line = 2^BLK_LEN*8/BEAT_W = 16
TAG_LEN, ADDR_W-IDX_LEN-BLK_LEN (19), tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
miss_req_i  in  1  miss pulse/level from fetch, sampled only in IDLE
miss_addr_i  in  ADDR_W  missing fetch address
refill_busy_o  out  1  engine not IDLE
refill_done_o  out  1  one-cycle completion pulse
refill_err_o  out  1  one-cycle pulse with done when the line was not validated
axi_ar_valid_o  out  1  AR valid
axi_ar_ready_i  in  1  AR ready
axi_ar_addr_o  out  ADDR_W  line-aligned address
axi_ar_len_o  out  8  constant 15
axi_ar_size_o  out  3  constant 3'b010
axi_ar_burst_o  out  2  constant 2'b01 (INCR)
axi_r_valid_i  in  1  R valid
axi_r_ready_o  out  1  R ready
axi_r_data_i  in  BEAT_W  R data
axi_r_resp_i  in  2  R response
axi_r_last_i  in  1  R last
icache_index_o  out  IDX_LEN  set index to data array
icache_blk_addr_o  out  BLK_LEN  {burst_count[3:2],4'b0}
icache_line_wdata_o  out  128  beat replicated 4x
icache_wmask_o  out  128  32 ones at lane burst_count[1:0]
burst_count_o  out  4  beat counter
icache_wen_o  out  1  data array write strobe
tag_wen_o  out  1  tag/valid write strobe
tag_index_o  out  IDX_LEN  tag array index
tag_o  out  TAG_LEN  tag to write

Behaviour:
- Reset (rst low, async): state IDLE, all outputs 0, latched address 0, counter 0, err flag 0.
- Constant outputs: axi_ar_len_o, axi_ar_size_o and axi_ar_burst_o hold their constant values at all times, including during reset.
- FSM states: IDLE, AR, RDATA, DONE.
- IDLE: on miss_req_i, latch miss_addr_i, clear counter and err flag, go to AR. Busy asserts the following cycle.
- AR: axi_ar_valid_o=1, addr = latched addr with low BLK_LEN bits zeroed. Valid stays stable until ar_ready; on handshake go to RDATA.
- RDATA: axi_r_ready_o=1.
  - Each beat (r_valid&r_ready): icache_wen_o=1 the same cycle (combinational from handshake), wmask = 0xFFFFFFFF << (burst_count[1:0]*32), then counter++.
  - Counter wraps 15->0 only on exit.
  - A resp != OKAY sets the sticky err flag; the beat is still written.
  - Count is authoritative. At beat 15, exit to DONE regardless of r_last.
  - r_last on beat <15 sets err and exits to DONE (no further ready).
  - r_last missing on beat 15 sets err.
- DONE (1 cycle):
  - refill_done_o=1.
  - tag_wen_o=1 only if err clear; refill_err_o=err.
  - Then IDLE; busy drops the next cycle.
- miss_req_i outside IDLE is ignored. Minimum miss-to-done is 19 cycles with zero-wait AXI.
- icache_index_o and tag_index_o hold the latched index whenever busy.
- icache_wen_o is never asserted outside RDATA.
- Reset mid-burst returns to IDLE immediately. The AXI slave shares this reset, so no drain is performed.

Optional Feature:
ICACHE_CRIT_FWD_EN:
- When defined, adds outputs fwd_valid_o (1) and fwd_data_o (32).
- fwd_valid_o pulses in the R-handshake cycle whose beat index equals latched addr[5:2], with fwd_data_o = r_data, so fetch resumes before DONE.
- The pulse is suppressed if resp != OKAY on that beat.
- When not defined, the ports are absent and fetch waits for refill_done_o.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - AXI constants: BURST_INCR, SIZE_4B, RESP_OKAY, LINE_BEATS=16.
  - IDX_LEN, BLK_LEN, TAG_LEN defaults.
- Optional sub-module icache_refill_lane: pure mapping burst_count -> {blk_addr, wmask, wdata replication}. The rest stays in one module.

Test Plan:
- Zero-wait refill, miss_addr=0x8000_1234:
  - Expect ar_addr=0x8000_1200, len=15.
  - 16 wen pulses with burst_count 0..15 and blk_addr 0x00/0x10/0x20/0x30.
  - tag_wen with index=0x48, tag=0x40000; done at cycle 19.
- Random r_valid gaps and 5-cycle ar_ready delay -> ar_valid held stable, wen only on handshakes, done exactly once.
- Beat 7 resp=SLVERR -> all 16 beats written, tag_wen=0, refill_err_o=1 with done.
- r_last on beat 9 -> exit after beat 9, refill_err_o=1, no tag write. Beat 15 without r_last -> err=1.
- rst low at beat 5 -> all outputs 0 asynchronously. A new miss after release starts a clean burst with burst_count=0.
- ICACHE_CRIT_FWD_EN, miss_addr=0x8000_003C -> fwd_valid pulses on beat 15 with that beat's data. miss_req_i held high during busy creates no second burst.
